// File: rtl/audio_pkg.sv
// Shared audio format definitions: bit-depth and sample-rate codes, parser states,
// and the bytes-per-frame mapping used by both the stream parser and tx_i2s.
package audio_pkg;

   typedef enum logic [1:0] {
      DEPTH_16  = 2'd0,
      DEPTH_24  = 2'd1,
      DEPTH_32  = 2'd2,
      DEPTH_DOP = 2'd3
   } depth_e;

   typedef enum logic [2:0] {
      RATE_44K1  = 3'd0,
      RATE_48K   = 3'd1,
      RATE_88K2  = 3'd2,
      RATE_96K   = 3'd3,
      RATE_176K4 = 3'd4,
      RATE_192K  = 3'd5,
      RATE_352K8 = 3'd6,
      RATE_384K  = 3'd7
   } rate_e;

   typedef struct packed {
      rate_e  rate;
      depth_e depth;
   } cfg_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CFG     = 3'd1,
      ST_LEN_HI  = 3'd2,
      ST_LEN_LO  = 3'd3,
      ST_WAIT_TX = 3'd4,
      ST_PAYLOAD = 3'd5
   } state_e;

   // 65535 frames x 8 bytes fits in 19 bits, so the payload counter never wraps.
   localparam int CNT_W = 19;

   // Stereo frame: two channels, DoP travels in a 24-bit container.
   function automatic logic [3:0] bytes_per_frame(input depth_e d);
      case (d)
         DEPTH_16:  bytes_per_frame = 4'd4;
         DEPTH_24:  bytes_per_frame = 4'd6;
         DEPTH_32:  bytes_per_frame = 4'd8;
         DEPTH_DOP: bytes_per_frame = 4'd6;
         default:   bytes_per_frame = 4'd4;
      endcase
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single-bit level crossing into clk_i.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/audio_stream_parser.sv
// Parses MAGIC/CFG/LEN framed packets from the USB FIFO and forwards the payload to
// the I2S output FIFO, switching format only while the I2S side is not streaming.
module audio_stream_parser
   import audio_pkg::*;
#(
   parameter logic [7:0] MAGIC       = 8'hA5,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic [7:0] rd_usb_FIFO_data_i,
   input  logic       rd_usb_FIFO_empty_i,
   output logic       rd_usb_FIFO_en_o,
   output logic       wr_output_FIFO_en_o,
   output logic [7:0] wr_output_FIFO_data_o,
   input  logic       wr_output_FIFO_afull_i,
   input  logic       rd_output_FIFO_streaming_i,
   output logic [2:0] sample_rate_o,
   output logic [1:0] bit_depth_o,
   output logic       busy_o,
   output logic       hdr_err_o,
   output logic [7:0] err_count_o
);

   state_e            state_q;
   logic              run_q;
   cfg_t              cur_cfg_q;
   cfg_t              new_cfg_q;
   logic [7:0]        len_hi_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              wr_en_q;
   logic [7:0]        wr_data_q;
   logic              hdr_err_q;
   logic [7:0]        err_cnt_q;

   logic              stream_sync;
   logic              rd_pop;
   logic              hdr_reject;
   logic [CNT_W-1:0]  len_total_d;

   sync_ff #(.STAGES(SYNC_STAGES)) u_stream_sync (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .d_i       (rd_output_FIFO_streaming_i),
      .q_o       (stream_sync)
   );

   // run_q keeps the parser parked for the first edge after reset release.
   always_comb begin
      rd_pop = 1'b0;
      if (reset_n_i && run_q && !rd_usb_FIFO_empty_i) begin
         case (state_q)
            ST_IDLE, ST_CFG, ST_LEN_HI, ST_LEN_LO: rd_pop = 1'b1;
            ST_PAYLOAD:                            rd_pop = !wr_output_FIFO_afull_i;
            default:                               rd_pop = 1'b0;
         endcase
      end
   end

   assign hdr_reject = rd_pop &&
                       (((state_q == ST_IDLE) && (rd_usb_FIFO_data_i != MAGIC)) ||
                        ((state_q == ST_CFG)  && (rd_usb_FIFO_data_i[7:5] != 3'b000)));

   assign len_total_d = CNT_W'({len_hi_q, rd_usb_FIFO_data_i}) *
                        CNT_W'(bytes_per_frame(new_cfg_q.depth));

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= ST_IDLE;
         run_q     <= 1'b0;
         cur_cfg_q <= '0;
         new_cfg_q <= '0;
         len_hi_q  <= '0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         hdr_err_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         run_q     <= 1'b1;
         wr_en_q   <= 1'b0;
         hdr_err_q <= hdr_reject;
         if (hdr_reject && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end

         case (state_q)
            ST_IDLE: begin
               if (rd_pop && !hdr_reject) state_q <= ST_CFG;
            end
            ST_CFG: begin
               if (rd_pop) begin
                  if (hdr_reject) begin
                     state_q <= ST_IDLE;
                  end else begin
                     new_cfg_q.rate  <= rate_e'(rd_usb_FIFO_data_i[4:2]);
                     new_cfg_q.depth <= depth_e'(rd_usb_FIFO_data_i[1:0]);
                     state_q         <= ST_LEN_HI;
                  end
               end
            end
            ST_LEN_HI: begin
               if (rd_pop) begin
                  len_hi_q <= rd_usb_FIFO_data_i;
                  state_q  <= ST_LEN_LO;
               end
            end
            ST_LEN_LO: begin
               if (rd_pop) begin
                  cnt_q <= len_total_d;
                  // Same format skips the drain wait so consecutive packets stay gapless.
                  if (len_total_d == '0)          state_q <= ST_IDLE;
                  else if (new_cfg_q == cur_cfg_q) state_q <= ST_PAYLOAD;
                  else                             state_q <= ST_WAIT_TX;
               end
            end
            ST_WAIT_TX: begin
               if (!stream_sync) begin
                  cur_cfg_q <= new_cfg_q;
                  state_q   <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (rd_pop) begin
                  wr_en_q   <= 1'b1;
                  wr_data_q <= rd_usb_FIFO_data_i;
                  cnt_q     <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rd_usb_FIFO_en_o      = rd_pop;
   assign wr_output_FIFO_en_o   = wr_en_q;
   assign wr_output_FIFO_data_o = wr_data_q;
   assign sample_rate_o         = cur_cfg_q.rate;
   assign bit_depth_o           = cur_cfg_q.depth;
   assign busy_o                = (state_q != ST_IDLE);
   assign hdr_err_o             = hdr_err_q;
   assign err_count_o           = err_cnt_q;

endmodule

// File: tb/tb_audio_stream_parser.sv
// Directed bench: a queue models the upstream FWFT FIFO, writes are captured per cycle.
module tb_audio_stream_parser;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] data;
   logic       empty;
   logic       rd_en;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       afull;
   logic       streaming;
   logic [2:0] rate;
   logic [1:0] depth;
   logic       busy;
   logic       hdr_err;
   logic [7:0] err_count;

   logic [7:0] fifo_q[$];
   logic [7:0] wq[$];
   int         wcyc[$];
   int         cyc = 0;
   int         underflow = 0;
   int         err_pulses = 0;
   logic       pop_armed = 1'b0;
   int         chk_cnt = 0;
   int         pass_cnt = 0;

   always #5 clk = ~clk;

   audio_stream_parser #(.MAGIC(8'hA5), .SYNC_STAGES(2)) dut (
      .clk_i                      (clk),
      .reset_n_i                  (reset_n),
      .rd_usb_FIFO_data_i         (data),
      .rd_usb_FIFO_empty_i        (empty),
      .rd_usb_FIFO_en_o           (rd_en),
      .wr_output_FIFO_en_o        (wr_en),
      .wr_output_FIFO_data_o      (wr_data),
      .wr_output_FIFO_afull_i     (afull),
      .rd_output_FIFO_streaming_i (streaming),
      .sample_rate_o              (rate),
      .bit_depth_o                (depth),
      .busy_o                     (busy),
      .hdr_err_o                  (hdr_err),
      .err_count_o                (err_count)
   );

   task automatic upd_fifo();
      if (fifo_q.size() != 0) begin
         data  = fifo_q[0];
         empty = 1'b0;
      end else begin
         data  = 8'h00;
         empty = 1'b1;
      end
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      upd_fifo();
   endtask

   task automatic push_pkt(input logic [7:0] cfg, input logic [15:0] len, input int nbytes,
                           input logic [7:0] base);
      push(8'hA5);
      push(cfg);
      push(len[15:8]);
      push(len[7:0]);
      for (int i = 0; i < nbytes; i++) push(base + 8'(i));
   endtask

   // Sample at negedge, then apply the pop just after the posedge the DUT popped on.
   task automatic tick();
      @(negedge clk);
      cyc++;
      pop_armed = rd_en;
      if (rd_en && empty) underflow++;
      if (wr_en) begin
         wq.push_back(wr_data);
         wcyc.push_back(cyc);
      end
      if (hdr_err) err_pulses++;
      @(posedge clk);
      #1;
      if (pop_armed && fifo_q.size() != 0) void'(fifo_q.pop_front());
      upd_fifo();
   endtask

   task automatic wait_writes(input int n, input int budget);
      int c = 0;
      while (wq.size() < n && c < budget) begin
         tick();
         c++;
      end
   endtask

   task automatic clr();
      wq.delete();
      wcyc.delete();
      err_pulses = 0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; afull = 1'b0; streaming = 1'b0;
      upd_fifo();
      repeat (3) @(posedge clk);
      #1;
      chk_cnt++; if (rd_en !== 1'b0)       $display("FAIL rst_rd_en got %0b exp 0", rd_en); else pass_cnt++;
      chk_cnt++; if (wr_en !== 1'b0)       $display("FAIL rst_wr_en got %0b exp 0", wr_en); else pass_cnt++;
      chk_cnt++; if (wr_data !== 8'h00)    $display("FAIL rst_wr_data got %0h exp 0", wr_data); else pass_cnt++;
      chk_cnt++; if (rate !== 3'd0)        $display("FAIL rst_rate got %0d exp 0", rate); else pass_cnt++;
      chk_cnt++; if (depth !== 2'd0)       $display("FAIL rst_depth got %0d exp 0", depth); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0)        $display("FAIL rst_busy got %0b exp 0", busy); else pass_cnt++;
      chk_cnt++; if (hdr_err !== 1'b0)     $display("FAIL rst_hdr_err got %0b exp 0", hdr_err); else pass_cnt++;
      chk_cnt++; if (err_count !== 8'h00)  $display("FAIL rst_err_count got %0h exp 0", err_count); else pass_cnt++;
      reset_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_basic();
      clr();
      push_pkt(8'h05, 16'd2, 12, 8'h10);
      wait_writes(12, 200);
      repeat (3) tick();
      chk_cnt++; if (wq.size() !== 12) $display("FAIL basic_count got %0d exp 12", wq.size()); else pass_cnt++;
      for (int i = 0; i < 12; i++) begin
         chk_cnt++;
         if (i >= wq.size() || wq[i] !== 8'h10 + 8'(i))
            $display("FAIL basic_byte%0d got %0h exp %0h", i, (i < wq.size()) ? wq[i] : 8'hxx, 8'h10 + 8'(i));
         else pass_cnt++;
      end
      chk_cnt++; if (rate !== 3'd1)    $display("FAIL basic_rate got %0d exp 1", rate); else pass_cnt++;
      chk_cnt++; if (depth !== 2'd1)   $display("FAIL basic_depth got %0d exp 1", depth); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0)    $display("FAIL basic_busy got %0b exp 0", busy); else pass_cnt++;
      chk_cnt++; if (err_pulses !== 0) $display("FAIL basic_errs got %0d exp 0", err_pulses); else pass_cnt++;
   endtask

   task automatic test_hdr_err();
      clr();
      push(8'h00);
      push(8'hFF);
      push_pkt(8'h00, 16'd1, 4, 8'h40);
      wait_writes(4, 200);
      repeat (3) tick();
      chk_cnt++; if (err_pulses !== 2)    $display("FAIL hdr_pulses got %0d exp 2", err_pulses); else pass_cnt++;
      chk_cnt++; if (err_count !== 8'd2)  $display("FAIL hdr_err_count got %0d exp 2", err_count); else pass_cnt++;
      chk_cnt++; if (wq.size() !== 4)     $display("FAIL hdr_count got %0d exp 4", wq.size()); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         chk_cnt++;
         if (i >= wq.size() || wq[i] !== 8'h40 + 8'(i))
            $display("FAIL hdr_byte%0d got %0h exp %0h", i, (i < wq.size()) ? wq[i] : 8'hxx, 8'h40 + 8'(i));
         else pass_cnt++;
      end
      chk_cnt++; if (depth !== 2'd0 || rate !== 3'd0)
         $display("FAIL hdr_cfg got %0d/%0d exp 0/0", rate, depth); else pass_cnt++;
   endtask

   task automatic test_cfg_err();
      clr();
      push(8'hA5);
      push(8'hE0);
      push_pkt(8'h00, 16'd1, 4, 8'h50);
      wait_writes(4, 200);
      repeat (3) tick();
      chk_cnt++; if (err_pulses !== 1)   $display("FAIL cfgerr_pulses got %0d exp 1", err_pulses); else pass_cnt++;
      chk_cnt++; if (err_count !== 8'd3) $display("FAIL cfgerr_err_count got %0d exp 3", err_count); else pass_cnt++;
      chk_cnt++; if (wq.size() !== 4)    $display("FAIL cfgerr_count got %0d exp 4", wq.size()); else pass_cnt++;
      chk_cnt++; if (wq.size() < 4 || wq[0] !== 8'h50 || wq[3] !== 8'h53)
         $display("FAIL cfgerr_bytes got size %0d exp 50..53", wq.size()); else pass_cnt++;
   endtask

   task automatic test_len0();
      clr();
      push(8'hA5); push(8'h05); push(8'h00); push(8'h00);
      repeat (10) tick();
      chk_cnt++; if (wq.size() !== 0)     $display("FAIL len0_writes got %0d exp 0", wq.size()); else pass_cnt++;
      chk_cnt++; if (rate !== 3'd0 || depth !== 2'd0)
         $display("FAIL len0_cfg got %0d/%0d exp 0/0", rate, depth); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0)       $display("FAIL len0_busy got %0b exp 0", busy); else pass_cnt++;
      chk_cnt++; if (fifo_q.size() !== 0) $display("FAIL len0_drain got %0d exp 0", fifo_q.size()); else pass_cnt++;
   endtask

   task automatic test_afull();
      int n0, f0;
      clr();
      push_pkt(8'h00, 16'd4, 16, 8'h60);
      wait_writes(4, 100);
      afull = 1'b1;
      tick();
      n0 = wq.size();
      f0 = fifo_q.size();
      repeat (9) tick();
      chk_cnt++; if (n0 !== 5)             $display("FAIL afull_inflight got %0d exp 5", n0); else pass_cnt++;
      chk_cnt++; if (wq.size() !== n0)     $display("FAIL afull_stall_writes got %0d exp %0d", wq.size(), n0); else pass_cnt++;
      chk_cnt++; if (fifo_q.size() !== f0) $display("FAIL afull_stall_pops got %0d exp %0d", fifo_q.size(), f0); else pass_cnt++;
      afull = 1'b0;
      wait_writes(16, 100);
      repeat (3) tick();
      chk_cnt++; if (wq.size() !== 16)     $display("FAIL afull_count got %0d exp 16", wq.size()); else pass_cnt++;
      for (int i = 0; i < 16; i++) begin
         chk_cnt++;
         if (i >= wq.size() || wq[i] !== 8'h60 + 8'(i))
            $display("FAIL afull_byte%0d got %0h exp %0h", i, (i < wq.size()) ? wq[i] : 8'hxx, 8'h60 + 8'(i));
         else pass_cnt++;
      end
   endtask

   task automatic test_wait_tx();
      int lat;
      clr();
      streaming = 1'b1;
      repeat (4) tick();
      push_pkt(8'h02, 16'd1, 8, 8'h80);
      repeat (20) tick();
      chk_cnt++; if (busy !== 1'b1)       $display("FAIL wtx_busy got %0b exp 1", busy); else pass_cnt++;
      chk_cnt++; if (fifo_q.size() !== 8) $display("FAIL wtx_no_pop got %0d exp 8", fifo_q.size()); else pass_cnt++;
      chk_cnt++; if (wq.size() !== 0)     $display("FAIL wtx_no_write got %0d exp 0", wq.size()); else pass_cnt++;
      chk_cnt++; if (depth !== 2'd0)      $display("FAIL wtx_depth_held got %0d exp 0", depth); else pass_cnt++;
      streaming = 1'b0;
      lat = 0;
      while (wq.size() == 0 && lat < 20) begin
         tick();
         lat++;
      end
      chk_cnt++; if (wq.size() == 0 || lat > 5)
         $display("FAIL wtx_latency got %0d exp <=5", lat); else pass_cnt++;
      chk_cnt++; if (depth !== 2'd2)      $display("FAIL wtx_depth got %0d exp 2", depth); else pass_cnt++;
      wait_writes(8, 100);
      for (int i = 0; i < 8; i++) begin
         chk_cnt++;
         if (i >= wq.size() || wq[i] !== 8'h80 + 8'(i))
            $display("FAIL wtx_byte%0d got %0h exp %0h", i, (i < wq.size()) ? wq[i] : 8'hxx, 8'h80 + 8'(i));
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      clr();
      streaming = 1'b1;
      repeat (4) tick();
      push_pkt(8'h02, 16'd1, 8, 8'h90);
      push_pkt(8'h02, 16'd1, 8, 8'hA0);
      wait_writes(16, 200);
      chk_cnt++; if (wq.size() !== 16) $display("FAIL b2b_count got %0d exp 16", wq.size()); else pass_cnt++;
      chk_cnt++; if (wq.size() < 16 || (wcyc[15] - wcyc[0]) !== 19)
         $display("FAIL b2b_span got %0d exp 19", (wq.size() < 16) ? -1 : wcyc[15] - wcyc[0]); else pass_cnt++;
      for (int i = 0; i < 16; i++) begin
         exp = (i < 8) ? 8'h90 + 8'(i) : 8'hA0 + 8'(i - 8);
         chk_cnt++;
         if (i >= wq.size() || wq[i] !== exp)
            $display("FAIL b2b_byte%0d got %0h exp %0h", i, (i < wq.size()) ? wq[i] : 8'hxx, exp);
         else pass_cnt++;
      end
      streaming = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_err_sat();
      clr();
      for (int i = 0; i < 260; i++) push(8'h00);
      repeat (270) tick();
      chk_cnt++; if (err_count !== 8'hFF) $display("FAIL sat_err_count got %0h exp ff", err_count); else pass_cnt++;
      chk_cnt++; if (err_pulses !== 260)  $display("FAIL sat_pulses got %0d exp 260", err_pulses); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      clr();
      push_pkt(8'h00, 16'd2, 8, 8'hC0);
      wait_writes(3, 100);
      reset_n = 1'b0;
      #1;
      chk_cnt++; if (rd_en !== 1'b0)      $display("FAIL mid_rd_en got %0b exp 0", rd_en); else pass_cnt++;
      chk_cnt++; if (wr_en !== 1'b0)      $display("FAIL mid_wr_en got %0b exp 0", wr_en); else pass_cnt++;
      chk_cnt++; if (wr_data !== 8'h00)   $display("FAIL mid_wr_data got %0h exp 0", wr_data); else pass_cnt++;
      chk_cnt++; if (rate !== 3'd0 || depth !== 2'd0)
         $display("FAIL mid_cfg got %0d/%0d exp 0/0", rate, depth); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0)       $display("FAIL mid_busy got %0b exp 0", busy); else pass_cnt++;
      chk_cnt++; if (err_count !== 8'h00) $display("FAIL mid_err_count got %0h exp 0", err_count); else pass_cnt++;
      fifo_q.delete();
      upd_fifo();
      repeat (2) tick();
      clr();
      push_pkt(8'h05, 16'd1, 6, 8'hD0);
      reset_n = 1'b1;
      tick();
      chk_cnt++; if (busy !== 1'b0)       $display("FAIL mid_release_busy got %0b exp 0", busy); else pass_cnt++;
      wait_writes(6, 100);
      repeat (3) tick();
      chk_cnt++; if (wq.size() !== 6)     $display("FAIL mid_count got %0d exp 6", wq.size()); else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         chk_cnt++;
         if (i >= wq.size() || wq[i] !== 8'hD0 + 8'(i))
            $display("FAIL mid_byte%0d got %0h exp %0h", i, (i < wq.size()) ? wq[i] : 8'hxx, 8'hD0 + 8'(i));
         else pass_cnt++;
      end
      chk_cnt++; if (rate !== 3'd1 || depth !== 2'd1)
         $display("FAIL mid_cfg_new got %0d/%0d exp 1/1", rate, depth); else pass_cnt++;
      chk_cnt++; if (err_pulses !== 0)    $display("FAIL mid_errs got %0d exp 0", err_pulses); else pass_cnt++;
   endtask

   task automatic test_no_underflow();
      chk_cnt++; if (underflow !== 0) $display("FAIL underflow got %0d exp 0", underflow); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hdr_err();
      test_cfg_err();
      test_len0();
      test_afull();
      test_wait_tx();
      test_back_to_back();
      test_err_sat();
      test_reset_mid();
      test_no_underflow();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/audio_stream_parser.md
AUDIO_STREAM_PARSER -- requirements
Module: audio_stream_parser

Interface
REQ-001 SHALL have parameter MAGIC, default 8'hA5, header sync byte.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for rd_output_FIFO_streaming_i.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i is the single clock, and reset_n_i is the asynchronous, active-low reset.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rd_usb_FIFO_data_i, input, 8, first-word-fall-through byte; valid whenever empty is low.
REQ-007 SHALL have port rd_usb_FIFO_empty_i, input, 1, upstream FIFO empty.
REQ-008 SHALL have port rd_usb_FIFO_en_o, output, 1, pop strobe; combinational, never high while empty is high.
REQ-009 SHALL have port wr_output_FIFO_en_o, output, 1, registered write strobe to the I2S output FIFO.
REQ-010 SHALL have port wr_output_FIFO_data_o, output, 8, registered write data.
REQ-011 SHALL have port wr_output_FIFO_afull_i, input, 1, output FIFO almost full (at least 2 free slots when first asserted).
REQ-012 SHALL have port rd_output_FIFO_streaming_i, input, 1, I2S streaming flag from a foreign clock domain.
REQ-013 SHALL have port sample_rate_o, output, 3, active sample-rate code.
REQ-014 SHALL have port bit_depth_o, output, 2, active bit-depth code.
REQ-015 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-016 SHALL have port hdr_err_o, output, 1, one-cycle pulse on a rejected header byte.
REQ-017 SHALL have port err_count_o, output, 8, saturating count of hdr_err_o pulses.

Function
REQ-018 SHALL parse the packet format MAGIC, CFG{3'b0, rate[2:0], depth[1:0]} (bits 7:5 zero, rate 4:2, depth 1:0), LEN_HI, LEN_LO, followed by payload of LEN (16-bit, frames) x bytes-per-frame.
REQ-019 SHALL use bytes-per-frame 4 for depth 16, 6 for depth 24 and DoP, and 8 for depth 32; the payload counter is 19 bits wide with no overflow.
REQ-020 SHALL use FSM states IDLE, CFG, LEN_HI, LEN_LO, WAIT_TX and PAYLOAD; each header state pops exactly one byte when not empty and advances.
REQ-021 SHALL, in IDLE, pop and discard any byte not equal to MAGIC, pulse hdr_err_o, and stay in IDLE to resynchronise.
REQ-022 SHALL, in CFG, on a byte with nonzero bits 7:5, pulse hdr_err_o and return to IDLE.
REQ-023 SHALL, after LEN_LO with LEN==0, return to IDLE with no payload and no config change.
REQ-024 SHALL, after LEN_LO with the new config equal to the current outputs, enter PAYLOAD directly so back-to-back packets produce no audio gap.
REQ-025 SHALL, after LEN_LO with a config that differs, enter WAIT_TX and hold there without popping until the synchronized streaming flag is low; it then updates sample_rate_o and bit_depth_o and enters PAYLOAD on the following cycle.
REQ-026 SHALL, in PAYLOAD, pop and forward one byte per cycle when not empty and afull is low; write strobe and data appear one cycle after the pop.
REQ-027 SHALL, in PAYLOAD, stall on empty or afull without losing or duplicating bytes.
REQ-028 SHALL decrement the remaining byte count on each pop; the pop at count 1 returns the FSM to IDLE on the next cycle.
REQ-029 SHALL hold err_count_o at 8'hFF once reached; a simultaneous pulse at 8'hFF is not counted.

Reset
REQ-030 SHALL, on reset assertion, asynchronously force state IDLE, rd_usb_FIFO_en_o 0, wr_output_FIFO_en_o 0, wr_output_FIFO_data_o 0, sample_rate_o 0, bit_depth_o 0 (16-bit code), busy_o 0, hdr_err_o 0, err_count_o 0 and all synchronizer stages 0.
REQ-031 SHALL, on reset mid-packet, discard the partial packet; after release the parser expects MAGIC.
REQ-032 SHALL release reset synchronously to clk_i (deassertion synchronized externally); no internal state SHALL leave IDLE in the cycle of deassertion.

Structure
REQ-033 SHALL take bit-depth codes (16=0, 24=1, 32=2, DoP=3), sample-rate codes and a bytes-per-frame function from shared package audio_pkg, which is also used by tx_i2s.
REQ-034 SHALL implement the streaming-flag crossing in sub-module sync_ff (SYNC_STAGES flops, reset to 0).

Verification
REQ-035 SHALL verify: A5 05 00 02 + 12 bytes (depth 24 = 1, rate 1) -> config outputs rate 1 / depth 1; 12 writes in order; busy_o low afterwards.
REQ-036 SHALL verify: 00 FF A5 00 00 01 + 4 bytes -> two hdr_err_o pulses and err_count_o=2; 4 bytes forwarded.
REQ-037 SHALL verify: afull held high for 10 cycles mid-payload -> no writes during the stall; byte sequence intact; total count exact.
REQ-038 SHALL verify: streaming high and new packet with depth 2 -> FSM holds in WAIT_TX with no pops; after streaming drops, depth updates and the first write follows within SYNC_STAGES+3 cycles.
REQ-039 SHALL verify: same-config second packet while streaming high -> no WAIT_TX; payload continues without gap.
REQ-040 SHALL verify: reset_n_i pulsed low after 3 payload bytes -> all outputs at reset values; a new full packet afterwards parses correctly.
